// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// The ops and FSM states live here so that decode and EX agree on one definition.
package ex_muldiv_pkg;

    localparam logic [2:0] md_op_mult  = 3'd0;
    localparam logic [2:0] md_op_multu = 3'd1;
    localparam logic [2:0] md_op_div   = 3'd2;
    localparam logic [2:0] md_op_divu  = 3'd3;
    localparam logic [2:0] md_op_mthi  = 3'd4;
    localparam logic [2:0] md_op_mtlo  = 3'd5;

    typedef enum logic [1:0] {
        md_st_idle = 2'd0,
        md_st_calc = 2'd1,
        md_st_done = 2'd2
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == md_op_div) || (op == md_op_divu);
    endfunction

    // Absolute value when the operand is to be treated as signed; raw otherwise.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle of the muldiv unit: operands and control in, stall and HI/LO out.
interface ex_muldiv_if;
    logic        ex_start;
    logic [2:0]  ex_op;
    logic [31:0] ex_rdata1;
    logic [31:0] ex_rdata2;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output ex_start, ex_op, ex_rdata1, ex_rdata2, flush,
        input  stall_req, busy, hi, lo
    );

    modport slave (
        input  ex_start, ex_op, ex_rdata1, ex_rdata2, flush,
        output stall_req, busy, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// 32-step unsigned restoring divider; one quotient bit per cycle after start.
// done is high during the final step, so results are stable the following cycle.
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {rem_q, quot_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done    = run_q && (cnt_q == 5'd31) && !flush;
        if (flush) begin
            run_d = 1'b0;
        end else if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            dvs_d  = divisor;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            // A borrow out of the 34-bit trial means the divisor did not fit.
            if (!diff[33]) begin
                rem_d  = diff[31:0];
                quot_d = {quot_q[30:0], 1'b1};
            end else begin
                rem_d  = shifted[31:0];
                quot_d = {quot_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit holding HI/LO. Multiplies and moves finish in one
// cycle; divides stall the front end while div_core iterates, then commit in DONE.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  md
);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

    logic        op_signed, core_start, core_done;
    logic [32:0] ext_a, ext_b;
    logic [63:0] prod;
    logic [31:0] core_quo, core_rem;

    assign op_signed = (md.ex_op == md_op_mult) || (md.ex_op == md_op_div);
    assign ext_a     = {op_signed & md.ex_rdata1[31], md.ex_rdata1};
    assign ext_b     = {op_signed & md.ex_rdata2[31], md.ex_rdata2};
    assign prod      = 64'($signed(ext_a)) * 64'($signed(ext_b));

    assign core_start = (state_q == md_st_idle) && md.ex_start && is_div_op(md.ex_op) && !md.flush;

    div_core u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .flush     (md.flush),
        .dividend  (mag(md.ex_rdata1, op_signed)),
        .divisor   (mag(md.ex_rdata2, op_signed)),
        .quotient  (core_quo),
        .remainder (core_rem),
        .done      (core_done)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        if (md.flush) begin
            state_d = md_st_idle;
        end else begin
            case (state_q)
                md_st_idle: if (md.ex_start) begin
                    case (md.ex_op)
                        md_op_mult, md_op_multu: {hi_d, lo_d} = prod;
                        md_op_mthi: hi_d = md.ex_rdata1;
                        md_op_mtlo: lo_d = md.ex_rdata1;
                        md_op_div, md_op_divu: begin
                            state_d   = md_st_calc;
                            neg_quo_d = op_signed && (md.ex_rdata1[31] ^ md.ex_rdata2[31]);
                            neg_rem_d = op_signed && md.ex_rdata1[31];
                            dz_d      = (md.ex_rdata2 == 32'd0);
                        end
                        default: ;
                    endcase
                end
                md_st_calc: if (core_done) state_d = md_st_done;
                md_st_done: begin
                    // On divide-by-zero the remainder is the dividend magnitude, so the
                    // dividend-sign fix below returns the original rs value unchanged.
                    lo_d    = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~core_quo + 32'd1) : core_quo);
                    hi_d    = neg_rem_q ? (~core_rem + 32'd1) : core_rem;
                    state_d = md_st_idle;
                end
                default: state_d = md_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= md_st_idle;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= (state_d != md_st_idle);
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign md.stall_req = !md.flush &&
                          (((state_q == md_st_idle) && md.ex_start && is_div_op(md.ex_op)) ||
                           (state_q == md_st_calc));
    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and random checks of ex_muldiv against an arithmetic HI/LO model.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if md();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference semantics straight from the instruction definitions.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sq, sr, sp;
        logic [63:0] up;
        case (op)
            md_op_mult: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                {m_hi, m_lo} = up;
            end
            md_op_multu: begin
                up = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = up;
            end
            md_op_div: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
            end
            md_op_divu: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            md_op_mthi: m_hi = a;
            md_op_mtlo: m_lo = a;
            default: ;
        endcase
    endtask

    // Presents one instruction in EX (held through any stall) and checks timing and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          stalls;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi; old_lo = m_lo;
        md.ex_op = op; md.ex_rdata1 = a; md.ex_rdata2 = b; md.ex_start = 1'b1;
        #1;
        if (op == md_op_div || op == md_op_divu) begin
            stalls = 0;
            while (md.stall_req && stalls < 40) begin
                stalls++;
                @(posedge clk); #1;
            end
            chk({tag, " stall_cycles"}, 32'(stalls), 32'd33);
            chk({tag, " busy_done"}, 32'(md.busy), 32'd1);
            chk({tag, " hi_hold"}, md.hi, old_hi);
            chk({tag, " lo_hold"}, md.lo, old_lo);
            @(posedge clk); #1;
            md.ex_start = 1'b0;
            chk({tag, " busy_after"}, 32'(md.busy), 32'd0);
        end else begin
            chk({tag, " no_stall"}, 32'(md.stall_req), 32'd0);
            @(posedge clk); #1;
            md.ex_start = 1'b0;
        end
        ref_op(op, a, b);
        chk({tag, " hi"}, md.hi, m_hi);
        chk({tag, " lo"}, md.lo, m_lo);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; md.ex_start = 1'b0; md.flush = 1'b0;
        md.ex_op = '0; md.ex_rdata1 = '0; md.ex_rdata2 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", md.hi, 32'd0);
        chk("reset lo", md.lo, 32'd0);
        chk("reset busy", 32'(md.busy), 32'd0);
        chk("reset stall", 32'(md.stall_req), 32'd0);
        rst = 1'b0;

        run_op("multu_max", md_op_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max hi_const", md.hi, 32'hFFFF_FFFE);
        run_op("mult_neg", md_op_mult, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg lo_const", md.lo, 32'hFFFF_FFFA);
        run_op("mthi", md_op_mthi, 32'h1234_5678, 32'd0);
        chk("mthi lo_kept", md.lo, 32'hFFFF_FFFA);
        run_op("div_m7_2", md_op_div, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2 lo_const", md.lo, 32'hFFFF_FFFD);
        run_op("divu_100_7", md_op_divu, 32'd100, 32'd7);
        run_op("divu_by0", md_op_divu, 32'd100, 32'd0);
        run_op("div_by0_neg", md_op_div, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", md_op_div, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf lo_const", md.lo, 32'h8000_0000);
        run_op("div_pos_neg", md_op_div, 32'd100, 32'hFFFF_FFF9);
        run_op("mtlo", md_op_mtlo, 32'hCAFE_F00D, 32'd0);
        run_op("undef6", 3'd6, 32'h1111_1111, 32'h2222_2222);
        run_op("undef7", 3'd7, 32'h3333_3333, 32'd0);

        // Flush at CALC counter 10 (T+11).
        md.ex_op = md_op_divu; md.ex_rdata1 = 32'h0000_DEAD; md.ex_rdata2 = 32'd5; md.ex_start = 1'b1;
        repeat (11) begin @(posedge clk); #1; end
        chk("flush pre_stall", 32'(md.stall_req), 32'd1);
        md.flush = 1'b1; #1;
        chk("flush stall_low", 32'(md.stall_req), 32'd0);
        @(posedge clk); #1;
        md.flush = 1'b0; md.ex_start = 1'b0;
        chk("flush busy", 32'(md.busy), 32'd0);
        chk("flush idle_stall", 32'(md.stall_req), 32'd0);
        chk("flush hi", md.hi, m_hi);
        chk("flush lo", md.lo, m_lo);
        run_op("divu_9_3", md_op_divu, 32'd9, 32'd3);

        // Flush on an IDLE multiply: no HI/LO write.
        md.ex_op = md_op_multu; md.ex_rdata1 = 32'd7; md.ex_rdata2 = 32'd9;
        md.ex_start = 1'b1; md.flush = 1'b1;
        @(posedge clk); #1;
        md.ex_start = 1'b0; md.flush = 1'b0;
        chk("flush_mult hi", md.hi, m_hi);
        chk("flush_mult lo", md.lo, m_lo);

        // Flush in DONE: the pending result is dropped.
        md.ex_op = md_op_divu; md.ex_rdata1 = 32'd50; md.ex_rdata2 = 32'd4; md.ex_start = 1'b1;
        repeat (33) begin @(posedge clk); #1; end
        chk("flush_done busy", 32'(md.busy), 32'd1);
        md.flush = 1'b1;
        @(posedge clk); #1;
        md.flush = 1'b0; md.ex_start = 1'b0;
        chk("flush_done hi", md.hi, m_hi);
        chk("flush_done lo", md.lo, m_lo);
        chk("flush_done busy_after", 32'(md.busy), 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        // Reset mid-CALC after HI/LO hold nonzero values.
        run_op("pre_rst_mult", md_op_multu, 32'hABCD_0123, 32'h0F0F_0F0F);
        md.ex_op = md_op_div; md.ex_rdata1 = 32'hFFFF_0000; md.ex_rdata2 = 32'd3; md.ex_start = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1; md.ex_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rst_mid hi", md.hi, 32'd0);
        chk("rst_mid lo", md.lo, 32'd0);
        chk("rst_mid busy", 32'(md.busy), 32'd0);
        chk("rst_mid stall", 32'(md.stall_req), 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("rst_quiet hi", md.hi, 32'd0);
        chk("rst_quiet lo", md.lo, 32'd0);
        chk("rst_quiet busy", 32'(md.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
